// File: rtl/adc_spi_pkg.sv
// Shared types and defaults for the ADC serial configuration writer.
// Also holds the word-packing helper used by the gain/offset control logic.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        FIN
    } state_t;

    localparam int ADC_WORD_BITS = 16;
    localparam int ADC_N_WORDS   = 3;

    localparam logic [3:0] ADC_ADDR_GAIN   = 4'h1;
    localparam logic [3:0] ADC_ADDR_OFFSET = 4'h2;
    localparam logic [3:0] ADC_ADDR_COMMIT = 4'h3;

    // Word 0 (gain) occupies the low bits so it is the first frame on the wire.
    function automatic logic [ADC_N_WORDS*ADC_WORD_BITS-1:0] pack_adc_words(
        input logic [11:0] gain,
        input logic [11:0] offset
    );
        return {{ADC_ADDR_COMMIT, 12'h000},
                {ADC_ADDR_OFFSET, offset},
                {ADC_ADDR_GAIN, gain}};
    endfunction

endpackage

// File: rtl/adc_spi_phase.sv
// SCLK half-period divider: emits a one-cycle half_tick every CLK_DIV cycles
// while enabled, and restarts from zero whenever it is disabled.
module adc_spi_phase #(
    parameter int CLK_DIV = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    output logic half_tick
);

    localparam int             DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign half_tick = en && (div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            div_cnt <= '0;
        else if (!en || half_tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

endmodule

// File: rtl/adc_spi_writer.sv
// Serial writer for the ADC control port: shifts N_WORDS frames out on
// ADC_SDATA with one ADC_SLOAD low window per frame, START/BUSY/DONE handshake.
module adc_spi_writer
    import adc_spi_pkg::*;
#(
    parameter int WORD_BITS  = ADC_WORD_BITS,
    parameter int N_WORDS    = ADC_N_WORDS,
    parameter int CLK_DIV    = 1,
    parameter int LSB_FIRST  = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           START,
    input  logic [N_WORDS*WORD_BITS-1:0]   WORDS,
    output logic                           BUSY,
    output logic                           DONE,
    output logic                           ADC_SLOAD,
    output logic                           ADC_SCLK,
    output logic                           ADC_SDATA
);

    localparam int TOTAL = N_WORDS * WORD_BITS;
    localparam int BW    = $clog2(WORD_BITS);
    localparam int WW    = $clog2(N_WORDS + 1);
    localparam int GW    = $clog2(GAP_CYCLES + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(N_WORDS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    state_t            state, state_nxt;
    logic [TOTAL-1:0]  shadow;
    logic [BW-1:0]     bit_cnt;
    logic [WW-1:0]     word_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              half_tick;
    logic              sload_q, sclk_q, sdata_q, busy_q, done_q;
    logic              sload_d, sclk_d, sdata_d, busy_d, done_d;

    function automatic logic pick_bit(input logic [TOTAL-1:0] v, input int w, input int b);
        int idx;
        idx = (LSB_FIRST != 0) ? b : WORD_BITS - 1 - b;
        return v[w*WORD_BITS + idx];
    endfunction

    adc_spi_phase #(.CLK_DIV(CLK_DIV)) u_phase (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .en        (state == SHIFT),
        .half_tick (half_tick)
    );

    wire accept  = START && (state == IDLE || state == FIN);
    wire bit_end = (state == SHIFT) && half_tick && sclk_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (START) state_nxt = SHIFT;
            SHIFT: if (bit_end && bit_cnt == BIT_LAST)
                       state_nxt = (word_cnt == WORD_LAST) ? FIN : GAP;
            GAP:   if (gap_cnt == GAP_LAST) state_nxt = SHIFT;
            FIN:   state_nxt = START ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: this block computes next-cycle pin values; the flops below make every output registered.
    always_comb begin
        sload_d = 1'b1;
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE, FIN: begin
                if (START) begin
                    sload_d = 1'b0;
                    busy_d  = 1'b1;
                    sdata_d = pick_bit(WORDS, 0, 0);
                end
            end
            SHIFT: begin
                sload_d = 1'b0;
                busy_d  = 1'b1;
                sclk_d  = sclk_q;
                sdata_d = sdata_q;
                if (half_tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_cnt != BIT_LAST) begin
                        sclk_d  = 1'b0;
                        sdata_d = pick_bit(shadow, int'(word_cnt), int'(bit_cnt) + 1);
                    end else begin
                        sload_d = 1'b1;
                        sclk_d  = 1'b0;
                        sdata_d = 1'b0;
                        if (word_cnt == WORD_LAST) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                busy_d = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    sload_d = 1'b0;
                    sdata_d = pick_bit(shadow, int'(word_cnt), 0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sload_q <= 1'b1;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sload_q <= sload_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Payload is frozen at acceptance; counters reload to zero at their terminal values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow   <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            gap_cnt  <= '0;
        end else if (accept) begin
            shadow   <= WORDS;
            bit_cnt  <= '0;
            word_cnt <= '0;
            gap_cnt  <= '0;
        end else if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
                bit_cnt  <= '0;
                word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else if (state == GAP) begin
            gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ADC_SLOAD = sload_q;
    assign ADC_SCLK  = sclk_q;
    assign ADC_SDATA = sdata_q;

endmodule

// File: tb/tb_adc_spi_writer.sv
// Scoreboard bench for adc_spi_writer: three parameterisations share CLK/RST_N,
// expected serial bits are queued at START and popped on each SCLK rise.
module tb_adc_spi_writer;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int sel = 0;
    bit exp_q[$];

    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [47:0] words_a = '0;
    logic [7:0]  words_b = '0;
    logic [31:0] words_c = '0;
    logic busy_a, done_a, sload_a, sclk_a, sdata_a;
    logic busy_b, done_b, sload_b, sclk_b, sdata_b;
    logic busy_c, done_c, sload_c, sclk_c, sdata_c;

    adc_spi_writer u_a (
        .CLK(CLK), .RST_N(RST_N), .START(start_a), .WORDS(words_a), .BUSY(busy_a),
        .DONE(done_a), .ADC_SLOAD(sload_a), .ADC_SCLK(sclk_a), .ADC_SDATA(sdata_a));

    adc_spi_writer #(.WORD_BITS(8), .N_WORDS(1), .CLK_DIV(3), .LSB_FIRST(0)) u_b (
        .CLK(CLK), .RST_N(RST_N), .START(start_b), .WORDS(words_b), .BUSY(busy_b),
        .DONE(done_b), .ADC_SLOAD(sload_b), .ADC_SCLK(sclk_b), .ADC_SDATA(sdata_b));

    adc_spi_writer #(.N_WORDS(2), .GAP_CYCLES(4)) u_c (
        .CLK(CLK), .RST_N(RST_N), .START(start_c), .WORDS(words_c), .BUSY(busy_c),
        .DONE(done_c), .ADC_SLOAD(sload_c), .ADC_SCLK(sclk_c), .ADC_SDATA(sdata_c));

    wire m_busy  = (sel == 0) ? busy_a  : (sel == 1) ? busy_b  : busy_c;
    wire m_done  = (sel == 0) ? done_a  : (sel == 1) ? done_b  : done_c;
    wire m_sload = (sel == 0) ? sload_a : (sel == 1) ? sload_b : sload_c;
    wire m_sclk  = (sel == 0) ? sclk_a  : (sel == 1) ? sclk_b  : sclk_c;
    wire m_sdata = (sel == 0) ? sdata_a : (sel == 1) ? sdata_b : sdata_c;

    function automatic int div_of(input int s);
        return (s == 1) ? 3 : 1;
    endfunction

    // Serial monitor: pops one expected bit per SCLK rise and checks phase lengths.
    initial begin : monitor
        logic prev_sclk, prev_sdata, e;
        int hi_cnt, lo_cnt;
        prev_sclk = 1'b0; prev_sdata = 1'b0; hi_cnt = 0; lo_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_sclk = 1'b0; prev_sdata = 1'b0; hi_cnt = 0; lo_cnt = 0;
            end else begin
                if (m_sclk) begin
                    checks++;
                    if (m_sdata !== prev_sdata) begin
                        errors++;
                        $display("FAIL sdata_stable: changed to %b while SCLK high (t=%0t)", m_sdata, $time);
                    end
                    if (!prev_sclk) begin
                        checks++;
                        if (lo_cnt != div_of(sel)) begin
                            errors++;
                            $display("FAIL sclk_low_phase: got %0d expected %0d", lo_cnt, div_of(sel));
                        end
                        checks++;
                        if (m_sload !== 1'b0) begin
                            errors++;
                            $display("FAIL sload_at_sample: got %b expected 0", m_sload);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_bit: got %b expected none", m_sdata);
                        end else begin
                            e = exp_q.pop_front();
                            if (m_sdata !== e) begin
                                errors++;
                                $display("FAIL serial_bit: got %b expected %b (t=%0t)", m_sdata, e, $time);
                            end
                        end
                    end
                    hi_cnt++;
                    lo_cnt = 0;
                end else begin
                    if (prev_sclk) begin
                        checks++;
                        if (hi_cnt != div_of(sel)) begin
                            errors++;
                            $display("FAIL sclk_high_phase: got %0d expected %0d", hi_cnt, div_of(sel));
                        end
                    end
                    hi_cnt = 0;
                    lo_cnt = m_sload ? 0 : lo_cnt + 1;
                end
                prev_sclk  = m_sclk;
                prev_sdata = m_sdata;
            end
        end
    end

    task automatic set_start(input int s, input logic v);
        case (s)
            0: start_a = v;
            1: start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic set_words(input int s, input logic [47:0] w);
        case (s)
            0: words_a = w;
            1: words_b = w[7:0];
            default: words_c = w[31:0];
        endcase
    endtask

    task automatic push_bits(input logic [47:0] w, input int nw, input int wb, input int lsb);
        for (int wi = 0; wi < nw; wi++)
            for (int b = 0; b < wb; b++)
                exp_q.push_back(w[wi*wb + ((lsb != 0) ? b : wb - 1 - b)]);
    endtask

    // Entered at the sample just after the acceptance edge; returns samples until DONE.
    task automatic follow(input int nw, input int wb, input int div, input int gap,
                          input bit scramble, input bit pulse, output int lat);
        int frame, period, limit;
        logic exp_sl;
        logic [63:0] r;
        frame  = wb * 2 * div;
        period = frame + gap;
        limit  = nw * frame + (nw - 1) * gap + 16;
        lat = -1;
        for (int n = 0; n < limit; n++) begin
            if (m_done === 1'b1) begin
                lat = n;
                break;
            end
            exp_sl = ((n % period) >= frame);
            checks++;
            if ({m_busy, m_sload} !== {1'b1, exp_sl}) begin
                errors++;
                $display("FAIL busy_sload n=%0d: got %b%b expected 1%b", n, m_busy, m_sload, exp_sl);
            end
            if (exp_sl) begin
                checks++;
                if ({m_sclk, m_sdata} !== 2'b00) begin
                    errors++;
                    $display("FAIL gap_quiet n=%0d: got sclk=%b sdata=%b expected 00", n, m_sclk, m_sdata);
                end
            end
            if (scramble) begin
                r = {$urandom(), $urandom()};
                words_a = r[47:0];
            end
            if (pulse) start_a = (n == 10 || n == 50);
            @(negedge CLK);
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL done_timeout: got no DONE expected within %0d cycles", limit);
        end else if ({m_busy, m_sload, m_sclk, m_sdata} !== 4'b0100) begin
            errors++;
            $display("FAIL done_cycle: got busy/sload/sclk/sdata=%b%b%b%b expected 0100",
                     m_busy, m_sload, m_sclk, m_sdata);
        end
    endtask

    task automatic do_transfer(input string name, input int s, input logic [47:0] w,
                               input int nw, input int wb, input int div, input int gap,
                               input int lsb, input bit scramble, input bit pulse);
        int lat, exp_lat;
        sel = s;
        set_words(s, w);
        push_bits(w, nw, wb, lsb);
        exp_lat = nw * wb * 2 * div + (nw - 1) * gap;
        @(negedge CLK);
        set_start(s, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        set_start(s, 1'b0);
        follow(nw, wb, div, gap, scramble, pulse, lat);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        @(negedge CLK);
        checks++;
        if ({m_busy, m_done, m_sload} !== 3'b001) begin
            errors++;
            $display("FAIL %s idle_after: got busy/done/sload=%b%b%b expected 001", name, m_busy, m_done, m_sload);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s bits_left: got %0d expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b1;
        #2 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            checks++;
            if ({m_busy, m_done, m_sload, m_sclk, m_sdata} !== 5'b00100) begin
                errors++;
                $display("FAIL reset_state inst=%0d: got %b%b%b%b%b expected 00100",
                         s, m_busy, m_done, m_sload, m_sclk, m_sdata);
            end
        end
        sel = 0;
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_defaults();
        do_transfer("defaults", 0, {16'hA5C3, 16'h0F0F, 16'h1234}, 3, 16, 1, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_msb_div3();
        do_transfer("msb_div3", 1, 48'h81, 1, 8, 3, 1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gap4();
        do_transfer("gap4", 2, {16'h0, 16'hBEEF, 16'h8001}, 2, 16, 1, 4, 1, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        do_transfer("start_ignored", 0, {16'h5A5A, 16'hC001, 16'h7E81}, 3, 16, 1, 1, 1, 1'b0, 1'b1);
    endtask

    task automatic test_shadow();
        do_transfer("shadow", 0, {16'h1357, 16'h9BDF, 16'h2468}, 3, 16, 1, 1, 1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [47:0] w;
        w = {16'hF00D, 16'h3C3C, 16'h0001};
        sel = 0;
        words_a = w;
        push_bits(w, 3, 16, 1);
        push_bits(w, 3, 16, 1);
        @(negedge CLK);
        start_a = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        follow(3, 16, 1, 1, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 98) begin
            errors++;
            $display("FAIL b2b first_latency: got %0d expected 98", lat);
        end
        @(negedge CLK);
        start_a = 1'b0;
        checks++;
        if ({m_busy, m_done, m_sload} !== 3'b100) begin
            errors++;
            $display("FAIL b2b restart_edge: got busy/done/sload=%b%b%b expected 100", m_busy, m_done, m_sload);
        end
        follow(3, 16, 1, 1, 1'b0, 1'b0, lat);
        checks++;
        if (lat != 98) begin
            errors++;
            $display("FAIL b2b second_latency: got %0d expected 98", lat);
        end
        @(negedge CLK);
        checks++;
        if ({m_busy, m_done, m_sload, exp_q.size() == 0} !== 4'b0011) begin
            errors++;
            $display("FAIL b2b idle_after: got busy/done/sload=%b%b%b left=%0d expected 001 left=0",
                     m_busy, m_done, m_sload, exp_q.size());
        end
    endtask

    task automatic test_reset_abort();
        sel = 0;
        words_a = {16'hA5C3, 16'h0F0F, 16'h1234};
        push_bits(words_a, 3, 16, 1);
        @(negedge CLK);
        start_a = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_a = 1'b0;
        repeat (40) @(negedge CLK);
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort busy_before: got %b expected 1", m_busy);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({m_busy, m_done, m_sload, m_sclk, m_sdata} !== 5'b00100) begin
            errors++;
            $display("FAIL abort async_reset: got %b%b%b%b%b expected 00100",
                     m_busy, m_done, m_sload, m_sclk, m_sdata);
        end
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if ({m_busy, m_done, m_sload} !== 3'b001) begin
                errors++;
                $display("FAIL abort wait_idle i=%0d: got busy/done/sload=%b%b%b expected 001",
                         i, m_busy, m_done, m_sload);
            end
        end
        do_transfer("after_abort", 0, {16'hA5C3, 16'h0F0F, 16'h1234}, 3, 16, 1, 1, 1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_msb_div3();
        test_gap4();
        test_start_ignored();
        test_shadow();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish before 2000000");
        $fatal(1);
    end

endmodule
